// File: rtl/stepper_pkg.sv
// Shared types, default timing and sizing helpers for the two-joint stepper pulse generator.
package stepper_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DIR_SETUP  = 3'd1,
        PULSE_HIGH = 3'd2,
        PULSE_LOW  = 3'd3,
        FINISH     = 3'd4
    } state_t;

    localparam int DEF_STEPS_W            = 32'sd8;
    localparam int DEF_PULSE_HIGH_CYCLES  = 32'sd100;
    localparam int DEF_STEP_PERIOD_CYCLES = 32'sd50000;
    localparam int DEF_DIR_SETUP_CYCLES   = 32'sd50;

    // The phase timer must hold the longest phase it ever times.
    function automatic int phase_timer_width(input int period_cycles, input int setup_cycles);
        int longest;
        if (period_cycles > setup_cycles) begin
            longest = period_cycles;
        end else begin
            longest = setup_cycles;
        end
        return $clog2(longest + 32'sd1);
    endfunction

endpackage

// File: rtl/step_axis_counter.sv
// One joint: remaining-step counter plus the registered STEP/DIR drive for that joint.
module step_axis_counter #(
    parameter int STEPS_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [STEPS_W-1:0] load_count,
    input  logic               load_dir,
    input  logic               pulse_start,
    input  logic               pulse_done,
    input  logic               clear,
    output logic               nonzero,
    output logic               step,
    output logic               dir
);

    localparam logic [STEPS_W-1:0] COUNT_ZERO = {STEPS_W{1'b0}};
    localparam logic [STEPS_W-1:0] COUNT_ONE  = {{(STEPS_W-1){1'b0}}, 1'b1};

    logic [STEPS_W-1:0] remaining_r;
    logic               step_r;
    logic               dir_r;

    // Count/direction register; clear outranks pulse_done so a halted pulse still drops STEP.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_r <= COUNT_ZERO;
            step_r      <= 1'b0;
            dir_r       <= 1'b0;
        end else if (load) begin
            remaining_r <= load_count;
            dir_r       <= load_dir;
            step_r      <= 1'b0;
        end else if (clear) begin
            remaining_r <= COUNT_ZERO;
            step_r      <= 1'b0;
        end else if (pulse_done) begin
            step_r <= 1'b0;
            if (remaining_r != COUNT_ZERO) begin
                remaining_r <= remaining_r - COUNT_ONE;
            end else begin
                remaining_r <= remaining_r;
            end
        end else if (pulse_start) begin
            step_r <= (remaining_r != COUNT_ZERO);
        end else begin
            remaining_r <= remaining_r;
            step_r      <= step_r;
            dir_r       <= dir_r;
        end
    end

    assign nonzero = (remaining_r != COUNT_ZERO);
    assign step    = step_r;
    assign dir     = dir_r;

endmodule

// File: rtl/stepper_pulse_gen.sv
// Drives two stepper joints in lockstep from a latched move; FSM, shared phase timer and dataReady edge detect.
module stepper_pulse_gen
    import stepper_pkg::*;
#(
    parameter int STEPS_W            = DEF_STEPS_W,
    parameter int PULSE_HIGH_CYCLES  = DEF_PULSE_HIGH_CYCLES,
    parameter int STEP_PERIOD_CYCLES = DEF_STEP_PERIOD_CYCLES,
    parameter int DIR_SETUP_CYCLES   = DEF_DIR_SETUP_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STEPS_W-1:0] steps1,
    input  logic [STEPS_W-1:0] steps2,
    input  logic               dir1,
    input  logic               dir2,
    input  logic               dataReady,
    input  logic               halt,
    output logic               stepperReady,
    output logic               step1_out,
    output logic               step2_out,
    output logic               dir1_out,
    output logic               dir2_out,
    output logic               moveDone
);

    localparam int TIMER_W = phase_timer_width(STEP_PERIOD_CYCLES, DIR_SETUP_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
    localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(DIR_SETUP_CYCLES - 32'sd1);
    localparam logic [TIMER_W-1:0] HIGH_LOAD  = TIMER_W'(PULSE_HIGH_CYCLES - 32'sd1);
    localparam logic [TIMER_W-1:0] LOW_LOAD   = TIMER_W'(STEP_PERIOD_CYCLES - PULSE_HIGH_CYCLES - 32'sd1);

    state_t             state_r;
    logic [TIMER_W-1:0] timer_r;
    logic               dr_q_r;
    logic               halt_req_r;
    logic               ready_r;
    logic               done_r;

    logic accept_s;
    logic timed_s;
    logic phase_end_s;
    logic halt_now_s;
    logic any_nz_s;
    logic nz1_s;
    logic nz2_s;
    logic pulse_start_s;
    logic pulse_done_s;
    logic clear_s;

    // Phase-boundary strobes; halt seen in the boundary cycle itself counts immediately.
    always_comb begin
        accept_s      = (state_r == IDLE) && dataReady && !dr_q_r;
        timed_s       = (state_r == DIR_SETUP) || (state_r == PULSE_HIGH) || (state_r == PULSE_LOW);
        phase_end_s   = timed_s && (timer_r == TIMER_ZERO);
        halt_now_s    = halt_req_r || halt;
        any_nz_s      = nz1_s || nz2_s;
        pulse_start_s = phase_end_s && !halt_now_s && any_nz_s && (state_r != PULSE_HIGH);
        pulse_done_s  = phase_end_s && (state_r == PULSE_HIGH);
        clear_s       = phase_end_s && halt_now_s;
    end

    // Move sequencing FSM with its phase timer and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            timer_r    <= TIMER_ZERO;
            dr_q_r     <= 1'b0;
            halt_req_r <= 1'b0;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            dr_q_r <= dataReady;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r    <= DIR_SETUP;
                        timer_r    <= SETUP_LOAD;
                        ready_r    <= 1'b0;
                        halt_req_r <= 1'b0;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                DIR_SETUP, PULSE_LOW: begin
                    halt_req_r <= halt_now_s;
                    if (!phase_end_s) begin
                        timer_r <= timer_r - TIMER_ONE;
                    end else if (halt_now_s || !any_nz_s) begin
                        state_r <= FINISH;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= PULSE_HIGH;
                        timer_r <= HIGH_LOAD;
                    end
                end
                PULSE_HIGH: begin
                    halt_req_r <= halt_now_s;
                    if (!phase_end_s) begin
                        timer_r <= timer_r - TIMER_ONE;
                    end else if (halt_now_s) begin
                        state_r <= FINISH;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= PULSE_LOW;
                        timer_r <= LOW_LOAD;
                    end
                end
                FINISH: begin
                    state_r    <= IDLE;
                    ready_r    <= 1'b1;
                    halt_req_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    timer_r    <= TIMER_ZERO;
                    ready_r    <= 1'b1;
                    halt_req_r <= 1'b0;
                end
            endcase
        end
    end

    step_axis_counter #(.STEPS_W(STEPS_W)) u_axis1 (
        .clk         (clk),
        .reset       (reset),
        .load        (accept_s),
        .load_count  (steps1),
        .load_dir    (dir1),
        .pulse_start (pulse_start_s),
        .pulse_done  (pulse_done_s),
        .clear       (clear_s),
        .nonzero     (nz1_s),
        .step        (step1_out),
        .dir         (dir1_out)
    );

    step_axis_counter #(.STEPS_W(STEPS_W)) u_axis2 (
        .clk         (clk),
        .reset       (reset),
        .load        (accept_s),
        .load_count  (steps2),
        .load_dir    (dir2),
        .pulse_start (pulse_start_s),
        .pulse_done  (pulse_done_s),
        .clear       (clear_s),
        .nonzero     (nz2_s),
        .step        (step2_out),
        .dir         (dir2_out)
    );

    assign stepperReady = ready_r;
    assign moveDone     = done_r;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Bench for stepper_pulse_gen with short timing; expected waveforms come from the move timing rules.
module tb_stepper_pulse_gen;

    localparam int SW = 8;
    localparam int H  = 2;
    localparam int P  = 5;
    localparam int D  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] steps1, steps2;
    logic          dir1, dir2, dataReady, halt;
    logic          stepperReady, step1_out, step2_out, dir1_out, dir2_out, moveDone;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    stepper_pulse_gen #(
        .STEPS_W(SW), .PULSE_HIGH_CYCLES(H), .STEP_PERIOD_CYCLES(P), .DIR_SETUP_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .steps1(steps1), .steps2(steps2), .dir1(dir1), .dir2(dir2),
        .dataReady(dataReady), .halt(halt), .stepperReady(stepperReady), .step1_out(step1_out),
        .step2_out(step2_out), .dir1_out(dir1_out), .dir2_out(dir2_out), .moveDone(moveDone)
    );

    always #5 clk = ~clk;

    // Offsets are cycles after the cycle in which dataReady rose (offset 0).
    function automatic int nat_finish(input int s1, input int s2);
        return 1 + D + ((s1 > s2) ? s1 : s2) * P;
    endfunction

    // Last cycle of the phase in progress at offset h (halt takes effect there).
    function automatic int boundary(input int h);
        int rel;
        if (h <= D) return D;
        rel = h - (D + 1);
        if ((rel % P) < H) return D + (rel / P) * P + H;
        return D + (rel / P + 1) * P;
    endfunction

    function automatic int stop_off(input int s1, input int s2, input int h);
        if (h >= 1 && h < nat_finish(s1, s2)) return boundary(h);
        return 1000000;
    endfunction

    function automatic int finish_off(input int s1, input int s2, input int h);
        int n;
        n = nat_finish(s1, s2);
        if (h >= 1 && h < n && boundary(h) + 1 < n) return boundary(h) + 1;
        return n;
    endfunction

    function automatic logic exp_step(input int n, input int o, input int stop);
        int i, r;
        if (o < D + 1) return 1'b0;
        i = (o - D - 1) / P;
        r = (o - D - 1) % P;
        return (i < n) && (r < H) && (D + 1 + i * P <= stop);
    endfunction

    function automatic int exp_pulses(input int n, input int stop);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (D + 1 + i * P <= stop) c++;
        return c;
    endfunction

    task automatic idle_gap();
        dataReady = 1'b0;
        halt      = 1'b0;
        @(posedge clk); #1;
    endtask

    // Launch one move, then check every output cycle by cycle against the timing rules.
    task automatic run_move(input int s1, input int s2, input logic d1, input logic d2,
                            input int h, input int hold, input int rp, input int ncyc);
        int    stop, fin, c1, c2;
        logic  p1, p2, e1, e2;
        stop = stop_off(s1, s2, h);
        fin  = finish_off(s1, s2, h);
        c1 = 0; c2 = 0; p1 = 1'b0; p2 = 1'b0;
        steps1 = SW'(s1); steps2 = SW'(s2); dir1 = d1; dir2 = d2;
        dataReady = 1'b1;
        halt = (h == 0);
        for (int o = 1; o <= ncyc; o++) begin
            @(posedge clk); #1;
            e1 = exp_step(s1, o, stop);
            e2 = exp_step(s2, o, stop);
            checks += 6;
            if (step1_out !== e1) begin fails++; $display("FAIL step1 off=%0d got=%b exp=%b s=%0d/%0d h=%0d", o, step1_out, e1, s1, s2, h); end
            if (step2_out !== e2) begin fails++; $display("FAIL step2 off=%0d got=%b exp=%b s=%0d/%0d h=%0d", o, step2_out, e2, s1, s2, h); end
            if (dir1_out !== d1) begin fails++; $display("FAIL dir1 off=%0d got=%b exp=%b", o, dir1_out, d1); end
            if (dir2_out !== d2) begin fails++; $display("FAIL dir2 off=%0d got=%b exp=%b", o, dir2_out, d2); end
            if (moveDone !== (o == fin)) begin fails++; $display("FAIL moveDone off=%0d got=%b exp=%b", o, moveDone, (o == fin)); end
            if (stepperReady !== (o > fin)) begin fails++; $display("FAIL ready off=%0d got=%b exp=%b", o, stepperReady, (o > fin)); end
            if (step1_out && !p1) c1++;
            if (step2_out && !p2) c2++;
            p1 = step1_out; p2 = step2_out;
            halt = (o == h);
            dataReady = (o < hold) || (o == rp);
        end
        checks += 2;
        if (c1 != exp_pulses(s1, stop)) begin fails++; $display("FAIL pulses1 got=%0d exp=%0d", c1, exp_pulses(s1, stop)); end
        if (c2 != exp_pulses(s2, stop)) begin fails++; $display("FAIL pulses2 got=%0d exp=%0d", c2, exp_pulses(s2, stop)); end
        idle_gap();
    endtask

    task automatic test_reset();
        reset = 1'b1; dataReady = 1'b0; halt = 1'b0;
        steps1 = '0; steps2 = '0; dir1 = 1'b0; dir2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({stepperReady, step1_out, step2_out, dir1_out, dir2_out, moveDone} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_values got=%b exp=100000",
                     {stepperReady, step1_out, step2_out, dir1_out, dir2_out, moveDone});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();        run_move(3, 1, 1'b1, 1'b0, -1, 1, -1, 22); endtask
    task automatic test_zero_move();    run_move(0, 0, 1'b1, 1'b1, -1, 1, -1, 7);  endtask
    task automatic test_held_ready();   run_move(1, 0, 1'b0, 1'b1, -1, 40, -1, 40); endtask
    task automatic test_halt_mid_pulse(); run_move(10, 0, 1'b1, 1'b0, 5, 1, -1, 10); endtask
    task automatic test_halt_on_accept(); run_move(2, 1, 1'b0, 1'b0, 0, 1, -1, 15); endtask
    task automatic test_edge_while_busy(); run_move(2, 2, 1'b1, 1'b1, -1, 1, 6, 20); endtask
    task automatic test_max_count();    run_move(255, 254, 1'b1, 1'b0, -1, 1, -1, nat_finish(255, 254) + 2); endtask

    task automatic test_reset_mid_move();
        steps1 = 8'd10; steps2 = 8'd0; dir1 = 1'b1; dir2 = 1'b0;
        dataReady = 1'b1;
        for (int o = 1; o <= 5; o++) begin
            @(posedge clk); #1;
            if (o == 4) begin
                checks++;
                if (step1_out !== 1'b1) begin fails++; $display("FAIL rst_mid_pulse got=%b exp=1", step1_out); end
            end
            dataReady = 1'b0;
            reset = (o == 4);
        end
        checks += 3;
        if (step1_out !== 1'b0) begin fails++; $display("FAIL rst_mid_step got=%b exp=0", step1_out); end
        if (stepperReady !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got=%b exp=1", stepperReady); end
        if (dir1_out !== 1'b0) begin fails++; $display("FAIL rst_mid_dir got=%b exp=0", dir1_out); end
        reset = 1'b0;
        idle_gap();
        run_move(2, 3, 1'b0, 1'b1, -1, 1, -1, 20);
    endtask

    task automatic test_random();
        int s1, s2, h, rp, f;
        for (int k = 0; k < 12; k++) begin
            s1 = $urandom_range(0, 6);
            s2 = $urandom_range(0, 6);
            h  = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, nat_finish(s1, s2) + 1);
            f  = finish_off(s1, s2, h);
            rp = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(2, f);
            run_move(s1, s2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), h, 1, rp, f + 3);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_move();
        test_held_ready();
        test_halt_mid_pulse();
        test_halt_on_accept();
        test_edge_while_busy();
        test_reset_mid_move();
        test_max_count();
        test_random();
        passed = checks - fails;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
